// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds FSM state, grant side and the muxed request bundle.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    SIDE_I,
    SIDE_D
  } arb_side_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  localparam mem_req_t REQ_NONE = '0;

  function automatic logic req_pending(
    input logic [3:0] rmask,
    input logic [3:0] wmask
  );
    return |{rmask, wmask};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Simple memory request/response bus used on all three arbiter ports.
// The requester drives the request fields; the responder returns rdata/resp.
interface mem_port_arbiter_if;

  logic [31:0] addr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;

  modport master (
    output addr, rmask, wmask, wdata,
    input  rdata, resp
  );

  modport slave (
    input  addr, rmask, wmask, wdata,
    output rdata, resp
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Two-way picker: lock favours data, otherwise round-robin
// against the side that was granted last.
module mem_arb_pick
  import rv32i_types::*;
(
  input  logic      imem_req,
  input  logic      dmem_req,
  input  logic      lock,
  input  arb_side_t last_grant,
  output logic      valid,
  output arb_side_t side
);

  always_comb begin
    valid = imem_req | dmem_req;
    side  = SIDE_I;
    unique case (1'b1)
      imem_req & dmem_req & lock:
        side = SIDE_D;
      imem_req & dmem_req & ~lock:
        side = (last_grant == SIDE_I) ? SIDE_D : SIDE_I;
      dmem_req & ~imem_req:
        side = SIDE_D;
      default:
        side = SIDE_I;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// One transaction at a time, with an idle bubble between grants.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lock,
  mem_port_arbiter_if.slave  imem,
  mem_port_arbiter_if.slave  dmem,
  mem_port_arbiter_if.master mem,
  output logic [CNT_W-1:0]   contention_cnt
);

  arb_state_t       state_q, state_d;
  arb_side_t        last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             imem_req, dmem_req;
  logic             pick_valid, waiting;
  arb_side_t        pick_side;
  mem_req_t         mreq;
  logic             unused_imem;

  assign imem_req = |imem.rmask;
  assign dmem_req = req_pending(dmem.rmask, dmem.wmask);

  // Instruction side is read-only.
  assign unused_imem = ^{imem.wmask, imem.wdata};

  mem_arb_pick u_pick (
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .lock       (lock),
    .last_grant (last_q),
    .valid      (pick_valid),
    .side       (pick_side)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SIDE_I;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = (pick_side == SIDE_D) ? SERVE_D : SERVE_I;
          last_d  = pick_side;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem.resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mreq      = REQ_NONE;
    imem.resp = 1'b0;
    dmem.resp = 1'b0;
    if (!rst) begin
      unique case (state_q)
        SERVE_I: begin
          mreq.addr  = imem.addr;
          mreq.rmask = imem.rmask;
          imem.resp  = mem.resp;
        end
        SERVE_D: begin
          mreq.addr  = dmem.addr;
          mreq.rmask = dmem.rmask;
          mreq.wmask = dmem.wmask;
          mreq.wdata = dmem.wdata;
          dmem.resp  = mem.resp;
        end
        default: ;
      endcase
    end
  end

  assign mem.addr   = mreq.addr;
  assign mem.rmask  = mreq.rmask;
  assign mem.wmask  = mreq.wmask;
  assign mem.wdata  = mreq.wdata;
  assign imem.rdata = mem.rdata;
  assign dmem.rdata = mem.rdata;

  assign waiting = (state_q == SERVE_I && dmem_req)
                || (state_q == SERVE_D && imem_req);

  // Saturating wait counter.
  assign cnt_d = (waiting && !(&cnt_q))
               ? cnt_q + CNT_W'(1) : cnt_q;

  assign contention_cnt = cnt_q;

  a_hold_i: assert property (@(posedge clk) disable iff (rst)
    (state_d == SERVE_I) |=>
      (rst || (imem_req && $stable(imem.addr)
               && $stable(imem.rmask))));

  a_hold_d: assert property (@(posedge clk) disable iff (rst)
    (state_d == SERVE_D) |=>
      (rst || (dmem_req && $stable(dmem.addr)
               && $stable(dmem.rmask)
               && $stable(dmem.wmask)
               && $stable(dmem.wdata))));

  a_one_resp: assert property (@(posedge clk)
    !(imem.resp && dmem.resp));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter.
// Reference model predicts grants, port contents and the wait counter.
module tb_mem_port_arbiter;
  import rv32i_types::*;

  localparam int          CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] KEY   = 32'hA5A5_5A5A;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lock = 1'b0;
  logic [CNT_W-1:0] contention_cnt;

  mem_port_arbiter_if imem ();
  mem_port_arbiter_if dmem ();
  mem_port_arbiter_if mem ();

  mem_port_arbiter #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .lock           (lock),
    .imem           (imem),
    .dmem           (dmem),
    .mem            (mem),
    .contention_cnt (contention_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  arb_side_t   grant_log[$];
  int          i_resp_n = 0;
  int          d_resp_n = 0;
  int          mem_lat = 0;
  logic        stale_pulse = 1'b0;
  logic [71:0] cap_req = '0;

  typedef enum {M_NONE, M_I, M_D} m_srv_t;
  m_srv_t    m_srv = M_NONE;
  arb_side_t m_last = SIDE_I;
  int        m_cnt = 0;

  task automatic check(input string nm,
                       input logic [71:0] act,
                       input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor + reference model, sampled mid-cycle.
  always @(negedge clk) begin
    logic        ip, dp, ie, de;
    logic [71:0] ep;
    arb_side_t   g;
    ip = |imem.rmask;
    dp = |{dmem.rmask, dmem.wmask};
    ep = '0;
    ie = 1'b0;
    de = 1'b0;
    if (!rst && m_srv == M_I) begin
      ep = {imem.addr, imem.rmask, 4'h0, 32'h0};
      ie = mem.resp;
    end
    if (!rst && m_srv == M_D) begin
      ep = {dmem.addr, dmem.rmask, dmem.wmask, dmem.wdata};
      de = mem.resp;
    end
    check("mem_port", {mem.addr, mem.rmask, mem.wmask, mem.wdata}, ep);
    check("imem_resp", 72'(imem.resp), 72'(ie));
    check("dmem_resp", 72'(dmem.resp), 72'(de));
    check("contention_cnt", 72'(contention_cnt), 72'(m_cnt));
    if (imem.resp) begin
      i_resp_n++;
      check("imem_resp_expected", 72'(exp_i.size() > 0), 72'(1));
      if (exp_i.size() > 0)
        check("imem_rdata", 72'(imem.rdata), 72'(exp_i.pop_front()));
    end
    if (dmem.resp) begin
      d_resp_n++;
      check("dmem_resp_expected", 72'(exp_d.size() > 0), 72'(1));
      if (exp_d.size() > 0)
        check("dmem_rdata", 72'(dmem.rdata), 72'(exp_d.pop_front()));
    end
    if (rst) begin
      m_srv  = M_NONE;
      m_last = SIDE_I;
      m_cnt  = 0;
    end else if (m_srv == M_NONE) begin
      if (ip || dp) begin
        if (ip && dp)
          g = lock ? SIDE_D : ((m_last == SIDE_I) ? SIDE_D : SIDE_I);
        else
          g = dp ? SIDE_D : SIDE_I;
        m_srv  = (g == SIDE_D) ? M_D : M_I;
        m_last = g;
        grant_log.push_back(g);
      end
    end else begin
      if (((m_srv == M_I && dp) || (m_srv == M_D && ip)) && m_cnt < CMAX)
        m_cnt++;
      if (mem.resp) m_srv = M_NONE;
    end
  end

  // Memory: answers after mem_lat cycles (random when negative).
  initial begin : mem_model
    int age;
    int cur_lat;
    age = 0;
    cur_lat = 0;
    mem.resp = 1'b0;
    mem.rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem.resp = 1'b0;
      mem.rdata = '0;
      if (stale_pulse) begin
        mem.resp = 1'b1;
        mem.rdata = 32'h5151_5151;
        stale_pulse = 1'b0;
      end else if (|{mem.rmask, mem.wmask}) begin
        if (age == 0)
          cur_lat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        if (age == cur_lat) begin
          mem.resp = 1'b1;
          mem.rdata = mem.addr ^ KEY;
          cap_req = {mem.addr, mem.rmask, mem.wmask, mem.wdata};
          age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic wait_resp(input bit is_d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? dmem.resp : imem.resp) && n < 500);
    check(is_d ? "dmem_timeout" : "imem_timeout",
          72'(is_d ? dmem.resp : imem.resp), 72'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic i_req(input logic [31:0] a, input logic [3:0] rm);
    imem.addr = a;
    imem.rmask = rm;
    exp_i.push_back(a ^ KEY);
    wait_resp(1'b0);
    imem.addr = '0;
    imem.rmask = '0;
  endtask

  task automatic d_req(input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
    dmem.addr = a;
    dmem.rmask = rm;
    dmem.wmask = wm;
    dmem.wdata = wd;
    exp_d.push_back(a ^ KEY);
    wait_resp(1'b1);
    dmem.addr = '0;
    dmem.rmask = '0;
    dmem.wmask = '0;
    dmem.wdata = '0;
  endtask

  task automatic d_rand();
    if ($urandom_range(0, 1) == 0)
      d_req($urandom(), 4'($urandom_range(1, 15)), 4'h0, 32'h0);
    else
      d_req($urandom(), 4'h0, 4'($urandom_range(1, 15)), $urandom());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_i.delete();
    exp_d.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    arb_side_t seq[$];
    imem.addr = '0;  imem.rmask = '0;
    imem.wmask = '0; imem.wdata = '0;
    dmem.addr = '0;  dmem.rmask = '0;
    dmem.wmask = '0; dmem.wdata = '0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("reset_cnt", 72'(contention_cnt), 72'(0));

    // Lone fetch, 3-cycle memory.
    mem_lat = 3;
    i_resp_n = 0;
    d_resp_n = 0;
    i_req(32'h6000_0000, 4'hF);
    idle(3);
    check("fetch_imem_resp_count", 72'(i_resp_n), 72'(1));
    check("fetch_dmem_resp_count", 72'(d_resp_n), 72'(0));

    // First contention after reset goes to data.
    do_reset();
    grant_log.delete();
    mem_lat = 2;
    fork
      i_req(32'h0000_1000, 4'hF);
      d_req(32'h0000_2000, 4'hF, 4'h0, 32'h0);
    join
    idle(2);
    check("first_contention_count", 72'(grant_log.size()), 72'(2));
    check("first_contention_grant0", 72'(grant_log[0]), 72'(SIDE_D));
    check("first_contention_grant1", 72'(grant_log[1]), 72'(SIDE_I));
    check("first_contention_cnt", 72'(contention_cnt), 72'(3));

    // Continuous contention alternates.
    grant_log.delete();
    mem_lat = 0;
    fork
      repeat (2) i_req($urandom(), 4'hF);
      repeat (2) d_req($urandom(), 4'h3, 4'h0, 32'h0);
    join
    idle(2);
    seq = '{SIDE_D, SIDE_I, SIDE_D, SIDE_I};
    check("rr_count", 72'(grant_log.size()), 72'(4));
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_grant%0d", k), 72'(grant_log[k]), 72'(seq[k]));

    // Lock holds data priority; fetch waits.
    grant_log.delete();
    mem_lat = 1;
    lock = 1'b1;
    fork
      i_req(32'h0000_3000, 4'hF);
      begin
        repeat (4) d_req($urandom(), 4'hF, 4'h0, 32'h0);
        lock = 1'b0;
      end
    join
    idle(2);
    seq = '{SIDE_D, SIDE_D, SIDE_D, SIDE_D, SIDE_I};
    check("lock_count", 72'(grant_log.size()), 72'(5));
    for (int k = 0; k < 5; k++)
      check($sformatf("lock_grant%0d", k), 72'(grant_log[k]), 72'(seq[k]));

    // Partial write passes straight through.
    d_req(32'h1000_0040, 4'h0, 4'b0011, 32'hDEAD_BEEF);
    check("write_port", cap_req,
          {32'h1000_0040, 4'h0, 4'b0011, 32'hDEAD_BEEF});

    // Reset mid-fetch, then a stale response.
    mem_lat = 10;
    imem.addr = 32'h7000_0000;
    imem.rmask = 4'hF;
    idle(3);
    rst = 1'b1;
    exp_i.delete();
    idle(1);
    imem.addr = '0;
    imem.rmask = '0;
    idle(1);
    rst = 1'b0;
    stale_pulse = 1'b1;
    i_resp_n = 0;
    d_resp_n = 0;
    idle(3);
    check("stale_imem_resp", 72'(i_resp_n), 72'(0));
    check("stale_dmem_resp", 72'(d_resp_n), 72'(0));
    check("stale_cnt", 72'(contention_cnt), 72'(0));
    check("stale_port", {mem.addr, mem.rmask, mem.wmask, mem.wdata}, 72'(0));

    // Long locked data access saturates the counter.
    mem_lat = 20;
    lock = 1'b1;
    fork
      i_req(32'h0000_4000, 4'hF);
      d_req(32'h0000_5000, 4'hF, 4'h0, 32'h0);
    join
    lock = 1'b0;
    check("cnt_saturated", 72'(contention_cnt), 72'(CMAX));

    // Random traffic with random lock and latency.
    do_reset();
    mem_lat = -1;
    fork
      repeat (30) begin
        idle($urandom_range(0, 3));
        i_req($urandom(), 4'($urandom_range(1, 15)));
      end
      repeat (30) begin
        idle($urandom_range(0, 3));
        d_rand();
      end
      begin
        repeat (150) begin
          idle(1);
          if ($urandom_range(0, 7) == 0) lock = ~lock;
        end
        lock = 1'b0;
      end
    join
    idle(3);
    check("drain_imem", 72'(exp_i.size()), 72'(0));
    check("drain_dmem", 72'(exp_d.size()), 72'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the contention counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports imem_addr  input  32, imem_rmask  input  4  instruction read request (nonzero rmask = request).
REQ-005 SHALL have ports imem_rdata  output  32, imem_resp  output  1  instruction read return.
REQ-006 SHALL have ports dmem_addr  input  32, dmem_rmask  input  4, dmem_wmask  input  4, dmem_wdata  input  32  data request (nonzero rmask or wmask = request).
REQ-007 SHALL have ports dmem_rdata  output  32, dmem_resp  output  1  data return.
REQ-008 SHALL have port lock  input  1  core holds an atomic reservation; data side gets priority.
REQ-009 SHALL have ports mem_addr  output  32, mem_rmask  output  4, mem_wmask  output  4, mem_wdata  output  32  shared memory request.
REQ-010 SHALL have ports mem_rdata  input  32, mem_resp  input  1  shared memory single-cycle response pulse.
REQ-011 SHALL have port contention_cnt  output  CNT_W  cycles a pending request waited while the other side was served.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-013 IDLE: only imem pending -> SERVE_I; only dmem pending -> SERVE_D; none -> stay IDLE.
REQ-014 IDLE, both pending, lock=1 -> SERVE_D.
REQ-015 IDLE, both pending, lock=0 -> grant side opposite to last_grant register (round-robin).
REQ-016 last_grant SHALL update to the granted side on every IDLE->SERVE transition.
REQ-017 In IDLE, mem_rmask and mem_wmask SHALL be 0; mem_addr/mem_wdata SHALL be 0.
REQ-018 In SERVE_I: mem_addr=imem_addr, mem_rmask=imem_rmask, mem_wmask=0, mem_wdata=0.
REQ-019 In SERVE_D: mem_addr, mem_rmask, mem_wmask, mem_wdata SHALL equal the dmem_* inputs.
REQ-020 imem_resp = mem_resp AND state==SERVE_I; dmem_resp = mem_resp AND state==SERVE_D (combinational).
REQ-021 imem_rdata and dmem_rdata SHALL both be mem_rdata (passthrough, qualified only by resp).
REQ-022 SERVE_x with mem_resp=1 -> IDLE next cycle; otherwise remain in SERVE_x.
REQ-023 Latency: request first seen in IDLE at cycle N drives mem port at N+1; minimum 1-cycle IDLE bubble between back-to-back transactions.
REQ-024 Requesters SHALL hold request signals stable from assertion until their resp; withdrawal while in IDLE is legal and drops the request; withdrawal while served is a protocol violation.
REQ-025 mem_resp while IDLE SHALL be ignored (no imem_resp/dmem_resp).
REQ-026 contention_cnt SHALL increment by 1 each cycle in SERVE_I with dmem pending or SERVE_D with imem pending; saturate at all-ones.

Reset
REQ-027 On rst: state=IDLE, last_grant=I (first contention goes to dmem), contention_cnt=0.
REQ-028 During rst all mem_* masks, imem_resp, dmem_resp SHALL be 0.
REQ-029 Reset mid-transaction SHALL abandon it; any later stale mem_resp falls under REQ-025.

Structure
REQ-030 State enum arb_state_t and grant enum arb_side_t SHALL live in shared package rv32i_types.
REQ-031 One sub-module natural: mem_arb_pick, combinational 2-way lock/round-robin picker (REQ-013..015).
REQ-032 Assertions SHALL flag REQ-024 violations and resp asserted to both sides.

Verification
REQ-033 Only imem_rmask=4'hF, addr 0x6000_0000, mem_resp 3 cycles after grant -> imem_resp once, rdata matches, dmem_resp never.
REQ-034 After reset both pending, lock=0 -> dmem served first, then imem; contention_cnt = dmem service cycles.
REQ-035 Both continuously pending, lock=0, 1-cycle memory -> grants alternate D,I,D,I over 4 transactions.
REQ-036 Both continuously pending, lock=1 -> dmem granted every transaction, imem waits until lock=0.
REQ-037 dmem_wmask=4'b0011, wdata 0xDEAD_BEEF -> mem_wmask=4'b0011, mem_wdata=0xDEAD_BEEF, mem_rmask=0.
REQ-038 rst asserted mid SERVE_I, then mem_resp pulse in IDLE -> no imem_resp, state IDLE, counter 0.
